// File: rtl/timestamp_capture_unit_pkg.sv
// Shared definitions for the timestamp capture unit: defaults, counter update
// sources and helpers for indexing the packed per-channel capture bus.
package timestamp_capture_unit_pkg;

    localparam int unsigned TIMESTAMP_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_TICK,
        UPD_LOAD,
        UPD_CLEAR
    } upd_e;

    function automatic int unsigned chan_idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Low bit of channel ch within a packed bus of w-bit slices.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/timestamp_capture_unit_channel.sv
// One capture channel: rising-edge detect, capture register, valid/ready
// output stage and sticky overflow flag.
module timestamp_capture_channel
    import timestamp_capture_unit_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic                       event_in,
    output logic [TIMESTAMP_WIDTH-1:0] cap_data,
    output logic                       cap_valid,
    input  logic                       cap_ready,
    output logic                       cap_overflow,
    input  logic                       ovf_clear
);

    logic event_q;
    logic armed;
    logic rise;
    logic drop;

    // armed stays low for the first cycle after reset so a level already
    // high at release is absorbed into event_q without capturing.
    assign rise = event_in && !event_q && armed;
    assign drop = rise && cap_valid && !cap_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            event_q      <= 1'b0;
            armed        <= 1'b0;
            cap_data     <= '0;
            cap_valid    <= 1'b0;
            cap_overflow <= 1'b0;
        end else begin
            event_q <= event_in;
            armed   <= 1'b1;

            if (rise) begin
                if (!cap_valid || cap_ready) begin
                    cap_data  <= timestamp;
                    cap_valid <= 1'b1;
                end
            end else if (cap_ready) begin
                cap_valid <= 1'b0;
            end

            if (drop) begin
                cap_overflow <= 1'b1;
            end else if (ovf_clear) begin
                cap_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timestamp_capture_unit.sv
// Free-running prescaled timestamp counter with run/hold, clear and preload,
// feeding N independent event-capture channels.
module timestamp_capture_unit
    import timestamp_capture_unit_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEFAULT,
    parameter int unsigned N_CHANNELS      = 4,
    parameter int unsigned PRESCALE        = 1,
    parameter int unsigned PRESCALE_WIDTH  = 16
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  run,
    input  logic                                  clear,
    input  logic                                  load,
    input  logic [TIMESTAMP_WIDTH-1:0]            load_value,
    output logic [TIMESTAMP_WIDTH-1:0]            timestamp,
    output logic                                  wrap,
    input  logic [N_CHANNELS-1:0]                 event_in,
    output logic [N_CHANNELS*TIMESTAMP_WIDTH-1:0] cap_data,
    output logic [N_CHANNELS-1:0]                 cap_valid,
    input  logic [N_CHANNELS-1:0]                 cap_ready,
    output logic [N_CHANNELS-1:0]                 cap_overflow,
    input  logic [N_CHANNELS-1:0]                 ovf_clear
);

    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic                      tick;
    upd_e                      upd;

    assign tick = run && (pcnt == PRESCALE_WIDTH'(PRESCALE - 1));

    always_comb begin
        upd = UPD_HOLD;
        if (clear) begin
            upd = UPD_CLEAR;
        end else if (load) begin
            upd = UPD_LOAD;
        end else if (tick) begin
            upd = UPD_TICK;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timestamp <= '0;
            pcnt      <= '0;
            wrap      <= 1'b0;
        end else begin
            // Prescaler restarts on anything that breaks a continuous run.
            if (clear || load || !run || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESCALE_WIDTH'(1);
            end

            wrap <= (upd == UPD_TICK) && (&timestamp);

            case (upd)
                UPD_CLEAR: timestamp <= '0;
                UPD_LOAD:  timestamp <= load_value;
                UPD_TICK:  timestamp <= timestamp + TIMESTAMP_WIDTH'(1);
                default:   timestamp <= timestamp;
            endcase
        end
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        timestamp_capture_channel #(
            .TIMESTAMP_WIDTH(TIMESTAMP_WIDTH)
        ) u_chan (
            .clk         (clk),
            .resetn      (resetn),
            .timestamp   (timestamp),
            .event_in    (event_in[i]),
            .cap_data    (cap_data[slice_lo(i, TIMESTAMP_WIDTH) +: TIMESTAMP_WIDTH]),
            .cap_valid   (cap_valid[i]),
            .cap_ready   (cap_ready[i]),
            .cap_overflow(cap_overflow[i]),
            .ovf_clear   (ovf_clear[i])
        );
    end

endmodule

// File: tb/tb_timestamp_capture_unit.sv
// Scoreboard bench: a cycle-level reference model queues expected captures,
// a negedge monitor pops and compares them on every completed transfer.
module tb_timestamp_capture_unit;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int PS = 3;
    localparam int PW = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           run = 1'b0;
    logic           clear = 1'b0;
    logic           load = 1'b0;
    logic [W-1:0]   load_value = '0;
    logic [W-1:0]   timestamp;
    logic           wrap;
    logic [N-1:0]   event_in = '0;
    logic [N*W-1:0] cap_data;
    logic [N-1:0]   cap_valid;
    logic [N-1:0]   cap_ready = '0;
    logic [N-1:0]   cap_overflow;
    logic [N-1:0]   ovf_clear = '0;

    always #5 clk = ~clk;

    timestamp_capture_unit #(
        .TIMESTAMP_WIDTH(W),
        .N_CHANNELS     (N),
        .PRESCALE       (PS),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .run         (run),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .timestamp   (timestamp),
        .wrap        (wrap),
        .event_in    (event_in),
        .cap_data    (cap_data),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .cap_overflow(cap_overflow),
        .ovf_clear   (ovf_clear)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: value after the most recent clock edge.
    int unsigned m_ts = 0;
    int unsigned m_streak = 0;
    bit          m_wrap = 0;
    bit [N-1:0]  m_valid = '0;
    bit [N-1:0]  m_ovf = '0;
    bit [N-1:0]  m_evq = '0;
    bit          m_armed = 0;
    int unsigned expq[N][$];

    task automatic model_step();
        if (!resetn) begin
            m_ts = 0; m_streak = 0; m_wrap = 0;
            m_valid = '0; m_ovf = '0; m_evq = '0; m_armed = 0;
            for (int i = 0; i < N; i++) expq[i].delete();
            return;
        end
        for (int i = 0; i < N; i++) begin
            bit rise;
            bit dropped;
            rise = event_in[i] && !m_evq[i] && m_armed;
            dropped = 0;
            if (rise) begin
                if (!m_valid[i] || cap_ready[i]) begin
                    expq[i].push_back(m_ts);
                    m_valid[i] = 1;
                end else begin
                    dropped = 1;
                end
            end else if (cap_ready[i]) begin
                m_valid[i] = 0;
            end
            if (dropped) m_ovf[i] = 1;
            else if (ovf_clear[i]) m_ovf[i] = 0;
            m_evq[i] = event_in[i];
        end
        m_armed = 1;
        m_wrap = 0;
        if (clear) begin
            m_ts = 0; m_streak = 0;
        end else if (load) begin
            m_ts = load_value; m_streak = 0;
        end else if (run) begin
            m_streak++;
            if (m_streak % PS == 0) begin
                m_wrap = (m_ts == (1 << W) - 1);
                m_ts = (m_ts + 1) % (1 << W);
            end
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("timestamp", timestamp, m_ts);
        check("wrap", wrap, m_wrap);
        check("cap_valid", cap_valid, m_valid);
        check("cap_overflow", cap_overflow, m_ovf);
        #1;
    endtask

    // A transfer completes at the next posedge whenever valid && ready here.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                for (int i = 0; i < N; i++) begin
                    if (cap_valid[i] && cap_ready[i]) begin
                        if (expq[i].size() == 0)
                            check($sformatf("cap_valid_unexpected%0d", i), cap_valid[i], 0);
                        else
                            check($sformatf("cap_data%0d", i), cap_data[i*W +: W], expq[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        resetn = 0;
        step(); step();
        resetn = 1;

        run = 1; repeat (10) step();
        run = 0; repeat (5) step();
        run = 1; repeat (4) step();

        load = 1; load_value = 8'hFE; step();
        load = 0; repeat (9) step();
        load = 1; load_value = 8'h80; step();
        load = 0; clear = 1; step();
        clear = 0; repeat (3) step();

        event_in[0] = 1; step();
        event_in[0] = 0; repeat (4) step();
        event_in[0] = 1; step();
        event_in[0] = 0; step();
        cap_ready[0] = 1; step();
        cap_ready[0] = 0; ovf_clear[0] = 1; step();
        ovf_clear[0] = 0; step();

        event_in = '1; step();
        cap_ready = '1; event_in = 4'b0100;
        repeat (50) step();
        event_in = '0; step();

        for (int k = 0; k < 4; k++) begin
            event_in[1] = 1; load = (k == 2); load_value = 8'h40; step();
            event_in[1] = 0; load = 0; step();
        end

        cap_ready = '0; event_in[3] = 1; step();
        event_in[3] = 0; step();
        event_in[3] = 1; step();
        resetn = 0; step();
        resetn = 1; repeat (3) step();
        event_in = '0; step();

        repeat (3000) begin
            resetn     = ($urandom_range(0, 199) != 0);
            run        = ($urandom_range(0, 9) != 0);
            clear      = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 29) == 0);
            load_value = W'($urandom);
            event_in   = N'($urandom);
            cap_ready  = N'($urandom);
            ovf_clear  = N'($urandom_range(0, 15) == 0 ? $urandom : 0);
            step();
        end

        resetn = 1; clear = 0; load = 0; ovf_clear = '0;
        event_in = '0; cap_ready = '1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timestamp_capture_unit.md
Name: timestamp_capture_unit

Overview:
- Free-running, parametrised timestamp counter with prescaler, run/hold, synchronous clear and preload.
- Adds N independent event-capture channels. Each channel latches the current timestamp on a rising edge of its event input.
- Each channel presents the captured value on a valid/ready handshake with a sticky overflow flag.
- Sits between the pulse front-end (events already synchronised to clk) and the packetiser/DMA stream mux.

Parameters:
- TIMESTAMP_WIDTH, 64, width of timestamp counter and capture data (min 8).
- N_CHANNELS, 4, number of capture channels (1..16).
- PRESCALE, 1, clk cycles per timestamp tick (>=1); 1 means increment every running cycle.
- PRESCALE_WIDTH, 16, width of internal prescale counter; PRESCALE must be < 2**PRESCALE_WIDTH.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- run  in  1  high: counter advances on ticks; low: counter holds its value (no clear).
- clear  in  1  single-cycle: timestamp <= 0.
- load  in  1  single-cycle: timestamp <= load_value.
- load_value  in  TIMESTAMP_WIDTH  preload value.
- timestamp  out  TIMESTAMP_WIDTH  current counter value (registered).
- wrap  out  1  one-cycle pulse on increment rollover.
- event_in  in  N_CHANNELS  per-channel event level, clk-synchronous.
- cap_data  out  N_CHANNELS*TIMESTAMP_WIDTH  channel i occupies bits [i*W +: W].
- cap_valid  out  N_CHANNELS  per-channel data valid.
- cap_ready  in  N_CHANNELS  per-channel consumer ready.
- cap_overflow  out  N_CHANNELS  sticky: a capture was dropped.
- ovf_clear  in  N_CHANNELS  single-cycle per-channel overflow clear.

Behaviour:

Reset (resetn low at posedge):
- timestamp, prescale count, wrap, cap_valid, cap_overflow, cap_data and edge-detect history all go to 0.

Counter update priority per cycle, highest first:
- clear: timestamp <= 0.
- load: timestamp <= load_value.
- run && tick: timestamp <= timestamp + 1.
- otherwise: hold.

Prescaler:
- Counts 0..PRESCALE-1 while run; tick = run && (pcnt == PRESCALE-1).
- pcnt returns to 0 on tick, and on clear, load or !run.
- First increment occurs PRESCALE cycles after run rises.

Wrap:
- wrap = 1 for exactly the cycle after an increment from all-ones to 0.
- Never asserted by clear or load.

Edge detect:
- edge[i] = event_in[i] && !event_q[i]; event_q is event_in registered.
- A held-high level produces one edge only.

Capture value:
- On edge[i], the channel captures the timestamp value present in that same cycle (pre-update value).
- cap_valid[i] rises the following cycle (latency 1).

Handshake, per channel:
- Transfer occurs when cap_valid && cap_ready.
- While cap_valid is high and not accepted, cap_data is stable.
- edge while !cap_valid: capture; valid <= 1.
- edge while cap_valid && cap_ready: new capture loaded; valid stays 1 (back-to-back, no bubble).
- edge while cap_valid && !cap_ready: edge dropped; data unchanged; cap_overflow <= 1.
- No edge && cap_ready: valid <= 0.

Overflow:
- Sticky until ovf_clear.
- If ovf_clear and a new drop coincide, overflow stays 1 (set wins).

Timestamp/capture interaction:
- clear or load in the same cycle as an edge: capture takes the pre-clear/pre-load value.
- Channels are fully independent; simultaneous edges on all channels capture the identical timestamp.

Reset mid-operation:
- Pending captures are discarded, valid drops and overflow clears.
- A high event_in at reset release does not capture (event_q resets to 0, but capture is gated for the first cycle after reset).

Decomposition:
- Shared package/header timestamp_defs: TIMESTAMP_WIDTH default, channel-index width function (clog2), slice-index macro for packed cap_data.
- Sub-module timestamp_capture_channel, instantiated N_CHANNELS times via generate.
  - Contains edge detect, capture register, valid/ready logic and overflow flag.
  - Ports: clk, resetn, timestamp, event_in, cap_data, cap_valid, cap_ready, cap_overflow, ovf_clear.
- Top level holds the counter, prescaler and wrap.

Test Plan:
- Reset then run=1, PRESCALE=1, 10 cycles -> timestamp counts 1..10; run=0 for 5 cycles -> holds at 10; run=1 -> resumes at 11.
- PRESCALE=4, run rises at cycle 0 -> timestamp increments at cycles 4, 8, 12; load_value=0x55 with load at cycle 6 -> 0x55 at cycle 7, next increment at cycle 11.
- W=8: load 0xFE, run -> 0xFF, then 0x00 with wrap pulsed exactly one cycle; clear at 0x80 -> 0, no wrap.
- Ch0 edge at timestamp=20 with cap_ready=0 -> cap_valid[0]=1, data=20; second edge at 25 -> data stays 20, overflow[0]=1; ready=1 -> valid drops; ovf_clear -> overflow 0.
- All 4 channels edge at timestamp=100 -> all capture 100 next cycle; ch2 held high 50 cycles -> single capture only.
- Ch1 ready=1 continuous, edges on alternate cycles at t=40, 42 -> data 40 then 42, valid stays high, no overflow; resetn low while valid -> valid=0, overflow=0, timestamp=0.
